// File: rtl/interco_pkg.sv
// rtl/interco_pkg.sv - shared crossbar helpers for decoder and arbiter sides
// Contents:
//   idx_width(n) : width of an initiator index for n lanes, never less than 1
package interco_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority search over a request vector
// Ports:
//   valid  in   NumIn     request lanes
//   ptr    in   IdxWidth  lane with highest priority this cycle
//   any    out  1         at least one lane is valid
//   idx    out  IdxWidth  first valid lane at or after ptr, wrapping modulo NumIn
//   onehot out  NumIn     one-hot of idx, zero when nothing is valid
module rr_pick
    import interco_pkg::*;
#(
    parameter  int unsigned NumIn    = 4,
    localparam int unsigned IdxWidth = idx_width(NumIn)
) (
    input  logic [NumIn-1:0]    valid,
    input  logic [IdxWidth-1:0] ptr,
    output logic                any,
    output logic [IdxWidth-1:0] idx,
    output logic [NumIn-1:0]    onehot
);

    // Two descending passes so the last write is the lowest lane of each
    // half: lanes below ptr are the fallback, lanes at/after ptr override.
    // This avoids a modulo on the index, so NumIn need not be a power of two.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int j = int'(NumIn) - 1; j >= 0; j--) begin
            if (valid[j] && (j < int'(ptr))) begin
                any       = 1'b1;
                idx       = IdxWidth'(j);
                onehot    = '0;
                onehot[j] = 1'b1;
            end
        end
        for (int j = int'(NumIn) - 1; j >= 0; j--) begin
            if (valid[j] && (j >= int'(ptr))) begin
                any       = 1'b1;
                idx       = IdxWidth'(j);
                onehot    = '0;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/target_arbiter.sv
// rtl/target_arbiter.sv - round-robin arbiter at the target end of the simplex crossbar
// Ports:
//   clk_i    in   1                  clock
//   rst_ni   in   1                  asynchronous reset, active-low
//   valid_i  in   NumIn              request valid per initiator lane
//   ready_o  out  NumIn              ready/grant per lane, one-hot or zero
//   data_i   in   NumIn x DataWidth  payload per lane
//   valid_o  out  1                  request valid to the target
//   ready_i  in   1                  target ready (valid/ready) or grant (req/gnt)
//   data_o   out  DataWidth          payload of the selected lane
//   idx_o    out  IdxWidth           index of the selected lane, for response routing
module target_arbiter
    import interco_pkg::*;
#(
    parameter  int unsigned NumIn     = 32,
    parameter  int unsigned DataWidth = 32,
    parameter  bit          AxiVldRdy = 1'b1,
    parameter  bit          OutReg    = 1'b0,
    localparam int unsigned IdxWidth  = idx_width(NumIn)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumIn-1:0]                valid_i,
    output logic [NumIn-1:0]                ready_o,
    input  logic [NumIn-1:0][DataWidth-1:0] data_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [DataWidth-1:0]            data_o,
    output logic [IdxWidth-1:0]             idx_o
);

    if (NumIn == 0) begin : g_bad_num_in
        $fatal(1, "target_arbiter: NumIn must be greater than 0");
    end
    if (OutReg && !AxiVldRdy) begin : g_bad_out_reg
        $fatal(1, "target_arbiter: OutReg requires AxiVldRdy");
    end

    // The winner is only frozen when the output is combinational and the
    // initiator is bound to hold its request; the output register already
    // keeps data_o stable, and req/gnt initiators may withdraw.
    localparam bit UseLock = AxiVldRdy && !OutReg && (NumIn > 1);

    logic [IdxWidth-1:0] rr_q;
    logic                lock_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic                out_valid_q;

    logic                pick_any;
    logic [IdxWidth-1:0] pick_idx;
    logic [NumIn-1:0]    pick_onehot;
    logic [IdxWidth-1:0] win_idx;
    logic [NumIn-1:0]    win_oh;
    logic                win_valid;
    logic                stage_rdy;
    logic                hs;

    rr_pick #(
        .NumIn (NumIn)
    ) u_rr_pick (
        .valid  (valid_i),
        .ptr    (rr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        win_idx   = pick_idx;
        win_oh    = pick_onehot;
        win_valid = pick_any;
        if (lock_q) begin
            win_idx             = lock_idx_q;
            win_oh              = '0;
            win_oh[lock_idx_q]  = 1'b1;
            win_valid           = |(valid_i & win_oh);
        end
    end

    assign stage_rdy = OutReg ? (!out_valid_q || ready_i) : ready_i;
    assign ready_o   = win_oh & {NumIn{stage_rdy}};
    assign hs        = win_valid && stage_rdy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            // The granted lane drops to lowest priority for the next search.
            if (hs) begin
                rr_q <= (win_idx == IdxWidth'(NumIn - 1)) ? '0 : win_idx + IdxWidth'(1);
            end
            if (UseLock) begin
                lock_q     <= win_valid && !stage_rdy;
                lock_idx_q <= win_idx;
            end
        end
    end

    if (OutReg) begin : g_out_reg
        logic [DataWidth-1:0] out_data_q;
        logic [IdxWidth-1:0]  out_idx_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_idx_q   <= '0;
            end else if (hs) begin
                out_valid_q <= 1'b1;
                out_data_q  <= data_i[win_idx];
                out_idx_q   <= win_idx;
            end else if (ready_i) begin
                out_valid_q <= 1'b0;
            end
        end

        assign valid_o = out_valid_q;
        assign data_o  = out_data_q;
        assign idx_o   = out_idx_q;
    end else begin : g_out_comb
        assign out_valid_q = 1'b0;
        assign valid_o     = win_valid;
        assign data_o      = data_i[win_idx];
        assign idx_o       = win_idx;
    end

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(ready_o));

    if (AxiVldRdy) begin : g_axi_checks
        a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (valid_o && !ready_i) |=> ($stable(data_o) && $stable(idx_o) && valid_o));
    end

endmodule

// File: tb/tb_target_arbiter.sv
// tb/tb_target_arbiter.sv - self-checking bench for target_arbiter
module tb_target_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] lane_data [4] = '{8'hA5, 8'hB1, 8'hC2, 8'hD3};

    // NumIn=4, valid/ready, combinational output
    logic [3:0]      a_valid, a_ready_o;
    logic [3:0][7:0] a_data;
    logic            a_ready_i, a_valid_o;
    logic [7:0]      a_data_o;
    logic [1:0]      a_idx_o;
    // NumIn=3, valid/ready
    logic [2:0]      t_valid, t_ready_o;
    logic [2:0][7:0] t_data;
    logic            t_ready_i, t_valid_o;
    logic [7:0]      t_data_o;
    logic [1:0]      t_idx_o;
    // NumIn=4, req/gnt
    logic [3:0]      g_valid, g_ready_o;
    logic [3:0][7:0] g_data;
    logic            g_ready_i, g_valid_o;
    logic [7:0]      g_data_o;
    logic [1:0]      g_idx_o;
    // NumIn=4, valid/ready, registered output
    logic [3:0]      r_valid, r_ready_o;
    logic [3:0][7:0] r_data;
    logic            r_ready_i, r_valid_o;
    logic [7:0]      r_data_o;
    logic [1:0]      r_idx_o;

    target_arbiter #(.NumIn(4), .DataWidth(8), .AxiVldRdy(1'b1), .OutReg(1'b0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid), .ready_o(a_ready_o), .data_i(a_data),
        .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o), .idx_o(a_idx_o));
    target_arbiter #(.NumIn(3), .DataWidth(8), .AxiVldRdy(1'b1), .OutReg(1'b0)) u_t (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(t_valid), .ready_o(t_ready_o), .data_i(t_data),
        .valid_o(t_valid_o), .ready_i(t_ready_i), .data_o(t_data_o), .idx_o(t_idx_o));
    target_arbiter #(.NumIn(4), .DataWidth(8), .AxiVldRdy(1'b0), .OutReg(1'b0)) u_g (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(g_valid), .ready_o(g_ready_o), .data_i(g_data),
        .valid_o(g_valid_o), .ready_i(g_ready_i), .data_o(g_data_o), .idx_o(g_idx_o));
    target_arbiter #(.NumIn(4), .DataWidth(8), .AxiVldRdy(1'b1), .OutReg(1'b1)) u_r (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(r_valid), .ready_o(r_ready_o), .data_i(r_data),
        .valid_o(r_valid_o), .ready_i(r_ready_i), .data_o(r_data_o), .idx_o(r_idx_o));

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_idx;
        logic [3:0] exp_ready;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        // valid, ready_i, exp valid_o, exp idx_o, exp ready_o
        vecs[0]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
        vecs[1]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
        vecs[2]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
        vecs[3]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100};
        vecs[4]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000};
        vecs[5]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
        vecs[6]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0000};
        vecs[7]  = '{4'b0101, 1'b0, 1'b1, 2'd0, 4'b0000};
        vecs[8]  = '{4'b0101, 1'b0, 1'b1, 2'd0, 4'b0000};
        vecs[9]  = '{4'b0101, 1'b1, 1'b1, 2'd0, 4'b0001};
        vecs[10] = '{4'b0101, 1'b1, 1'b1, 2'd2, 4'b0100};
        vecs[11] = '{4'b0101, 1'b1, 1'b1, 2'd0, 4'b0001};
        vecs[12] = '{4'b1010, 1'b1, 1'b1, 2'd1, 4'b0010};
        vecs[13] = '{4'b1010, 1'b1, 1'b1, 2'd3, 4'b1000};
        vecs[14] = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000};
        vecs[15] = '{4'b1000, 1'b0, 1'b1, 2'd3, 4'b0000};
        vecs[16] = '{4'b1001, 1'b0, 1'b1, 2'd3, 4'b0000};
        vecs[17] = '{4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000};
        vecs[18] = '{4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001};
        vecs[19] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};

        a_valid = '0; a_ready_i = 1'b0;
        t_valid = '0; t_ready_i = 1'b0;
        g_valid = '0; g_ready_i = 1'b0;
        r_valid = '0; r_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_data[k] = lane_data[k];
            g_data[k] = lane_data[k];
            r_data[k] = lane_data[k];
        end
        for (int k = 0; k < 3; k++) t_data[k] = lane_data[k];
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst a valid_o", 32'(a_valid_o), 32'd0);
        check("rst a ready_o", 32'(a_ready_o), 32'd0);
        check("rst r valid_o", 32'(r_valid_o), 32'd0);
        check("rst r data_o", 32'(r_data_o), 32'd0);
        check("rst r idx_o", 32'(r_idx_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin, stall lock and lock ignoring a higher-priority newcomer
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_valid   = vecs[i].valid;
            a_ready_i = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d valid_o", i), 32'(a_valid_o), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d ready_o", i), 32'(a_ready_o), 32'(vecs[i].exp_ready));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d idx_o", i), 32'(a_idx_o), 32'(vecs[i].exp_idx));
                check($sformatf("vec%0d data_o", i), 32'(a_data_o), 32'(lane_data[vecs[i].exp_idx]));
            end
        end
        @(negedge clk);
        a_valid = '0; a_ready_i = 1'b0;

        // NumIn=3: pointer wraps 2 -> 0
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            t_valid = 3'b111; t_ready_i = 1'b1;
            #1;
            check($sformatf("n3 cyc%0d idx_o", i), 32'(t_idx_o), 32'(i % 3));
            check($sformatf("n3 cyc%0d ready_o", i), 32'(t_ready_o), 32'(1 << (i % 3)));
        end
        @(negedge clk);
        t_valid = '0; t_ready_i = 1'b0;

        // req/gnt: withdrawn request, winner switches the same cycle
        @(negedge clk);
        g_valid = 4'b0010; g_ready_i = 1'b0;
        #1;
        check("gnt lane1 valid_o", 32'(g_valid_o), 32'd1);
        check("gnt lane1 idx_o", 32'(g_idx_o), 32'd1);
        check("gnt lane1 ready_o", 32'(g_ready_o), 32'd0);
        @(negedge clk);
        g_valid = 4'b1000;
        #1;
        check("gnt switch idx_o", 32'(g_idx_o), 32'd3);
        check("gnt switch data_o", 32'(g_data_o), 32'hD3);
        @(negedge clk);
        g_ready_i = 1'b1;
        #1;
        check("gnt grant ready_o", 32'(g_ready_o), 32'b1000);
        @(negedge clk);
        g_valid = 4'b0011;
        #1;
        check("gnt wrap idx_o", 32'(g_idx_o), 32'd0);
        check("gnt wrap ready_o", 32'(g_ready_o), 32'b0001);
        @(negedge clk);
        #1;
        check("gnt next idx_o", 32'(g_idx_o), 32'd1);
        @(negedge clk);
        g_valid = '0;
        #1;
        check("gnt idle valid_o", 32'(g_valid_o), 32'd0);
        g_ready_i = 1'b0;

        // OutReg: 8 back-to-back beats from lane 2, one cycle latency
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            r_valid = 4'b0100; r_data[2] = 8'(k); r_ready_i = 1'b1;
            #1;
            check($sformatf("oreg beat%0d ready_o", k), 32'(r_ready_o), 32'b0100);
            check($sformatf("oreg beat%0d valid_o", k), 32'(r_valid_o), 32'(k != 0));
            if (k != 0) begin
                check($sformatf("oreg beat%0d data_o", k), 32'(r_data_o), 32'(k - 1));
                check($sformatf("oreg beat%0d idx_o", k), 32'(r_idx_o), 32'd2);
            end
        end
        @(negedge clk);
        r_valid = '0;
        #1;
        check("oreg last valid_o", 32'(r_valid_o), 32'd1);
        check("oreg last data_o", 32'(r_data_o), 32'd7);
        @(negedge clk);
        #1;
        check("oreg drained valid_o", 32'(r_valid_o), 32'd0);

        // OutReg: reset in the middle of a stall
        @(negedge clk);
        r_valid = 4'b0010; r_data[1] = 8'h55; r_ready_i = 1'b0;
        #1;
        check("stall accept ready_o", 32'(r_ready_o), 32'b0010);
        @(negedge clk);
        #1;
        check("stall valid_o", 32'(r_valid_o), 32'd1);
        check("stall data_o", 32'(r_data_o), 32'h55);
        check("stall idx_o", 32'(r_idx_o), 32'd1);
        check("stall ready_o", 32'(r_ready_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst valid_o", 32'(r_valid_o), 32'd0);
        check("midrst data_o", 32'(r_data_o), 32'd0);
        check("midrst idx_o", 32'(r_idx_o), 32'd0);
        @(negedge clk);
        r_valid = 4'b1111; r_ready_i = 1'b1; r_data[1] = lane_data[1];
        rst_n = 1'b1;
        #1;
        check("postrst ready_o", 32'(r_ready_o), 32'b0001);
        @(negedge clk);
        r_valid = '0;
        #1;
        check("postrst valid_o", 32'(r_valid_o), 32'd1);
        check("postrst idx_o", 32'(r_idx_o), 32'd0);
        check("postrst data_o", 32'(r_data_o), 32'hA5);
        @(negedge clk);
        r_ready_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
